// File: rtl/residual_pkg.sv
// Shared types and constants for the residual adder arbiter.
// Optional feature macro: RESIDUAL_ARB_TIMEOUT_EN (engine busy timeout).
package residual_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Width of the engine-busy timeout counter; must hold TIMEOUT_CYCLES-1.
  localparam int TO_CNT_W = 16;

endpackage : residual_pkg

// File: rtl/residual_arb_rr_pick.sv
// Combinational round-robin picker: searches from last_ptr_i+1 upward,
// wrapping at NUM_REQ-1 -> 0, and returns the first requesting index.
module rr_pick
  import residual_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] winner_o,
  output logic                       valid_o
);

  localparam int IW = $clog2(NUM_REQ);

  // Walk the NUM_REQ candidates in priority order; the first hit wins.
  always_comb begin
    logic [IW:0]   raw_v;
    logic [IW-1:0] idx_v;
    winner_o = '0;
    valid_o  = 1'b0;
    raw_v    = '0;
    idx_v    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      raw_v    = {1'b0, last_ptr_i} + (IW+1)'(k);
      raw_v    = (raw_v >= (IW+1)'(NUM_REQ)) ? (raw_v - (IW+1)'(NUM_REQ)) : raw_v;
      idx_v    = raw_v[IW-1:0];
      winner_o = (req_i[idx_v] && !valid_o) ? idx_v : winner_o;
      valid_o  = valid_o | req_i[idx_v];
    end
  end

endmodule : rr_pick

// File: rtl/residual_arb.sv
// Round-robin arbiter granting one shared residual adder engine to one of
// NUM_REQ requesters per job (IDLE -> START -> WAIT -> RELEASE).
// Optional feature macro: RESIDUAL_ARB_TIMEOUT_EN aborts a job whose engine
// stays busy for TIMEOUT_CYCLES WAIT cycles and pulses err with req_done.
// All outputs come from registers or from decoding the registered state.
module residual_arb
  import residual_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [$clog2(NUM_REQ)-1:0] sel,
  output logic                       eng_start,
  input  logic                       eng_done,
  output logic                       busy,
  output logic                       err
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      last_ptr_q, last_ptr_d;
  logic [IW-1:0]      pick_idx_s;
  logic               pick_valid_s;

`ifdef RESIDUAL_ARB_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TO_CNT_W'(TIMEOUT_CYCLES);
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i      (req),
    .last_ptr_i (last_ptr_q),
    .winner_o   (pick_idx_s),
    .valid_o    (pick_valid_s)
  );

  // Next-state and next-register logic for the job FSM.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    last_ptr_d = last_ptr_q;
`ifdef RESIDUAL_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          sel_d   = pick_idx_s;
          gnt_d   = NUM_REQ'(1) << pick_idx_s;
          state_d = START;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      START: begin
        // eng_done is deliberately not looked at here.
`ifdef RESIDUAL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          state_d = RELEASE;
        end else begin
`ifdef RESIDUAL_ARB_TIMEOUT_EN
          if (cnt_q == TO_LAST) begin
            state_d = RELEASE;
            err_d   = 1'b1;
          end else begin
            cnt_d   = cnt_q + TO_CNT_W'(1);
            state_d = WAIT;
          end
`else
          state_d = WAIT;
`endif
        end
      end
      RELEASE: begin
        last_ptr_d = sel_q;
        gnt_d      = '0;
        state_d    = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      gnt_q      <= '0;
      last_ptr_q <= IW'(NUM_REQ - 1);
`ifdef RESIDUAL_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      last_ptr_q <= last_ptr_d;
`ifdef RESIDUAL_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);
  assign eng_start = (state_q == START);
  assign req_done  = (state_q == RELEASE) ? gnt_q : '0;
`ifdef RESIDUAL_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule : residual_arb

// File: tb/tb_residual_arb.sv
// Self-checking bench for residual_arb (NUM_REQ=2, TIMEOUT_CYCLES=16).
// A job-level model predicts every output each cycle; directed literal
// expectations pin the model at the key scenarios.
module tb_residual_arb;

  localparam int N  = 2;
  localparam int TO = 16;
`ifdef RESIDUAL_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         eng_done = 1'b0;
  logic [N-1:0] gnt;
  logic [N-1:0] req_done;
  logic [0:0]   sel;
  logic         eng_start;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  residual_arb #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .req_done  (req_done),
    .sel       (sel),
    .eng_start (eng_start),
    .eng_done  (eng_done),
    .busy      (busy),
    .err       (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level model: who owns the engine, whether the start pulse has been
  // issued, how long it has been waiting, and whether it is being released.
  int m_owner   = -1;
  int m_last    = N - 1;
  int m_wait    = 0;
  bit m_started = 1'b0;
  bit m_release = 1'b0;
  bit m_to      = 1'b0;

  // Advance the model on each clock edge using the inputs seen at that edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_release = 1'b0; m_to = 1'b0; m_started = 1'b0;
    end else if (m_release) begin
      m_last = m_owner; m_owner = -1; m_release = 1'b0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && req[(m_last + k) % N]) m_owner = (m_last + k) % N;
      end
      m_started = 1'b0;
    end else if (!m_started) begin
      m_started = 1'b1; m_wait = 0;
    end else if (eng_done) begin
      m_release = 1'b1;
    end else if (TIMEOUT_ON && m_wait == TO - 1) begin
      m_release = 1'b1; m_to = 1'b1;
    end else begin
      m_wait++;
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    logic [N-1:0] e_one;
    if (chk_en) begin
      e_one = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      check("gnt",       gnt,       e_one);
      check("busy",      busy,      (m_owner >= 0));
      check("eng_start", eng_start, (m_owner >= 0 && !m_started));
      check("req_done",  req_done,  m_release ? e_one : '0);
      check("err",       err,       (m_release && m_to));
      if (m_owner >= 0) check("sel", sel, m_owner);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (eng_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("eng_start_seen", eng_start, 1);
  endtask

  logic [N-1:0] order [4];
  logic [N-1:0] exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    // Reset values.
    tick();
    chk_en = 1'b1;
    check("rst_gnt", gnt, 0);
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_req_done", req_done, 0);
    check("rst_err", err, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single request: grant at cycle 1, done at 5, req_done at 6, idle at 7.
    req = 2'b01;
    tick();
    check("single_gnt", gnt, 2'b01);
    check("single_start", eng_start, 1);
    repeat (4) tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("single_req_done", req_done, 2'b01);
    req = 2'b00;
    tick();
    check("single_idle", busy, 0);

    // Contention from reset: grants rotate 0,1,0,1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_start();
      order[j] = gnt;
      repeat (3) tick();
      pulse_done();
      if (j == 3) req = 2'b00;
    end
    for (int j = 0; j < 4; j++) check("rr_order", order[j], exp_order[j]);
    tick();
    tick();

    // Spurious eng_done in IDLE and START; then requester drops req mid-job.
    pulse_done();
    check("spur_idle_busy", busy, 0);
    req = 2'b10;
    tick();
    check("spur_start", eng_start, 1);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    tick();
    tick();
    check("spur_still_busy", busy, 1);
    check("spur_no_done", req_done, 0);
    req = 2'b00;
    tick();
    tick();
    pulse_done();
    check("drop_req_done", req_done, 2'b10);
    tick();
    tick();

    // Reset during WAIT: outputs clear at once, next grant goes to 0.
    req = 2'b11;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("rstjob_gnt", gnt, 0);
    check("rstjob_busy", busy, 0);
    check("rstjob_done", req_done, 0);
    check("rstjob_sel", sel, 0);
    tick();
    rst = 1'b0;
    wait_start();
    check("rstjob_next_gnt", gnt, 2'b01);
    tick();
    pulse_done();
    req = 2'b00;
    tick();
    tick();

    // Engine never answers.
    req = 2'b01;
    tick();
    tick();
    repeat (15) tick();
    check("to_not_yet", err, 0);
    tick();
`ifdef RESIDUAL_ARB_TIMEOUT_EN
    check("to_err", err, 1);
    check("to_req_done", req_done, 2'b01);
    req = 2'b00;
    tick();
    tick();
`else
    check("noto_busy", busy, 1);
    check("noto_no_done", req_done, 0);
    repeat (20) tick();
    check("noto_busy_late", busy, 1);
    req = 2'b00;
    pulse_done();
    tick();
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_residual_arb
